// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth product accumulator.
// ACC_SATURATE_EN selects clamping instead of wrapping on accumulator overflow.
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam int unsigned PRODUCT_W     = 64;
  localparam int unsigned ACC_W_DEFAULT = 72;
  localparam int unsigned SAT_MAX_W     = 128;

  // Largest positive value of a signed field of the given width, right-aligned.
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned width);
    return (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
  endfunction

  // Most negative value of a signed field of the given width, right-aligned.
  function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned width);
    return SAT_MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed ACC_W adder with overflow flag.
// Clamps to the signed range only when ACC_SATURATE_EN is defined; otherwise wraps.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] raw;

  assign raw = a + b;
  // Same-sign operands with a result of the opposite sign.
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SatPos = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SatNeg = ACC_W'(sat_min(ACC_W));

  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[ACC_W-1] ? SatNeg : SatPos;
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Dot-product accumulator for the 64-bit signed Booth multiplier output stream.
// ACC_SATURATE_EN (in booth_sat_add) selects saturating instead of wrapping accumulation.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned VEC_LEN = 16,
  parameter int unsigned ACC_W   = ACC_W_DEFAULT,
  localparam int unsigned CNT_W  = $clog2(VEC_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PRODUCT_W-1:0]    in_product,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_ovf_q, out_ovf_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic [CNT_W-1:0]        cnt_next;
  logic                    accept;
  logic                    is_final;

  assign prod_ext = ACC_W'($signed(in_product));

  booth_sat_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .a  (acc_q),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // rst_n gates in_ready so nothing is offered as accepted while held in reset.
  assign in_ready  = rst_n && (state_q != StHold);
  assign accept    = in_valid && in_ready;
  assign cnt_next  = cnt_q + CNT_W'(1);
  assign is_final  = in_last || (cnt_next == CNT_W'(VEC_LEN));

  assign out_valid = (state_q == StHold);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_next;
            ovf_d = ovf_q | add_ovf;
            if (is_final) begin
              state_d     = StHold;
              out_sum_d   = add_sum;
              out_count_d = cnt_next;
              out_ovf_d   = ovf_q | add_ovf;
            end else begin
              state_d = StAccum;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
